// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, instruction field positions and
// the fetch-stage state encoding.
package cpu_pkg;

  localparam int INSTR_W = 8;

  // Instruction layout: mode[7], opcode[6:4], regA[3:2], regB[1:0]
  localparam int MODE_BIT = 7;
  localparam int OPC_HI   = 6;
  localparam int OPC_LO   = 4;
  localparam int RA_HI    = 3;
  localparam int RA_LO    = 2;
  localparam int RB_HI    = 1;
  localparam int RB_LO    = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO; entry 0 is always the head so the head register
// only changes on a pop or on a push into an empty queue.
module fetch_fifo #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] e0_q, e0_d;
  logic [W-1:0] e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_pop;
  logic         do_push;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  // A push into a full queue is only accepted when a pop frees a slot.
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10: begin
        if (cnt_q == 2'd0) e0_d = din_i;
        else               e1_d = din_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          e0_d = din_i;
        end else begin
          e0_d = e1_q;
          e1_d = din_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = e0_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Program store plus fetch stage: loads words while idle, then streams them
// through a registered read and a 2-entry queue to the decoder.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int AW      = $clog2(DEPTH),
  parameter int INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic               clock_pulse,
  input  logic               reset,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               start,
  input  logic               clear,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [AW:0]        pc,
  output logic [AW:0]        prog_len,
  output logic               load_full,
  output logic               busy,
  output logic               done,
  output fetch_state_t       dbg_state_o
);

  // Handshake: a word transfers on every cycle where instr_valid & instr_ready
  // are both high; while instr_valid & !instr_ready, instr and instr_valid hold.

  localparam logic [AW:0] ONE     = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [INSTR_W-1:0] mem_q [DEPTH];

  fetch_state_t       state_q, state_d;
  logic [AW:0]        pc_q, pc_d;
  logic [AW:0]        prog_len_q, prog_len_d;
  logic               inflight_q;
  logic [INSTR_W-1:0] rd_data_q;

  logic               issue;
  logic               mem_we;
  logic               pop;
  logic [1:0]         fifo_cnt;
  logic [INSTR_W-1:0] fifo_head;
  logic [2:0]         occ_after;

  assign pop       = instr_valid && instr_ready;
  // Slots that will be taken once this cycle's pop completes; in-flight reads
  // count as taken so the queue can never overflow.
  assign occ_after = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, pop};
  assign load_full = (prog_len_q == DEPTH_L);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    prog_len_d = prog_len_q;
    issue      = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          if (!load_full) begin
            mem_we     = 1'b1;
            prog_len_d = prog_len_q + ONE;
          end
        end else if (start && (prog_len_q != '0)) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end
      end
      ST_RUN: begin
        if ((pc_q < prog_len_q) && (occ_after < 3'd2)) begin
          issue = 1'b1;
          pc_d  = pc_q + ONE;
          if (pc_d == prog_len_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The pending push is exactly the in-flight read.
        if (!inflight_q && ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end else if (clear) begin
          state_d    = ST_IDLE;
          prog_len_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_pulse) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      prog_len_q <= '0;
      inflight_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      prog_len_q <= prog_len_d;
      inflight_q <= issue;
      if (issue) rd_data_q <= mem_q[pc_q[AW-1:0]];
    end
  end

  // Program memory is deliberately not reset.
  always_ff @(posedge clock_pulse) begin
    if (mem_we && !reset) mem_q[prog_len_q[AW-1:0]] <= load_data;
  end

  fetch_fifo #(
    .W (INSTR_W)
  ) u_fifo (
    .clk_i   (clock_pulse),
    .rst_i   (reset),
    .push_i  (inflight_q),
    .din_i   (rd_data_q),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_cnt)
  );

  assign instr       = fifo_head;
  assign instr_valid = (fifo_cnt != 2'd0);
  assign pc          = pc_q;
  assign prog_len    = prog_len_q;
  assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done        = (state_q == ST_DONE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed plus randomized bench for instr_fetch_unit; expected words come
// from a program model and a scoreboard queue.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic         clock_pulse = 1'b0;
  logic         reset       = 1'b1;
  logic         load_valid  = 1'b0;
  logic [7:0]   load_data   = '0;
  logic         start       = 1'b0;
  logic         clear       = 1'b0;
  logic         instr_ready = 1'b0;
  logic [7:0]   instr;
  logic         instr_valid;
  logic [AW:0]  pc;
  logic [AW:0]  prog_len;
  logic         load_full;
  logic         busy;
  logic         done;
  fetch_state_t dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] prog_q[$];
  logic [7:0] exp_q[$];

  instr_fetch_unit #(.DEPTH(DEPTH)) dut (
    .clock_pulse (clock_pulse),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .start       (start),
    .clear       (clear),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .prog_len    (prog_len),
    .load_full   (load_full),
    .busy        (busy),
    .done        (done),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clock_pulse = ~clock_pulse;

  task automatic tick();
    @(posedge clock_pulse);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    prog_q.delete();
    exp_q.delete();
  endtask

  // driver tasks
  task automatic load_word(input logic [7:0] data);
    load_valid = 1'b1;
    load_data  = data;
    tick();
    load_valid = 1'b0;
    if (prog_q.size() < DEPTH) prog_q.push_back(data);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_q = prog_q;
  endtask

  // Consumes the expected stream, checking order, hold-while-stalled and the
  // done timing one cycle after the final acceptance.
  task automatic run_check(input string tag, input int budget, input bit rand_ready);
    int         cyc   = 0;
    bit         stall = 1'b0;
    logic [7:0] held  = '0;
    while (exp_q.size() > 0 && cyc < budget) begin
      instr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall) begin
        check({tag, "_hold_valid"}, 32'(instr_valid), 32'd1);
        check({tag, "_hold_instr"}, 32'(instr), 32'(held));
      end
      if (instr_valid && instr_ready) check({tag, "_instr"}, 32'(instr), 32'(exp_q.pop_front()));
      stall = instr_valid && !instr_ready;
      held  = instr;
      tick();
      cyc++;
    end
    check({tag, "_remaining"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_no_extra"}, 32'(instr_valid), 32'd0);
    instr_ready = 1'b0;
  endtask

  initial begin
    int n;
    int len;

    // reset state
    do_reset();
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_len", 32'(prog_len), 32'd0);
    check("rst_full", 32'(load_full), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // basic program, latency and throughput
    load_word(8'h14);
    check("load_len1", 32'(prog_len), 32'd1);
    load_word(8'h30);
    load_word(8'h91);
    check("load_len3", 32'(prog_len), 32'd3);
    instr_ready = 1'b1;
    pulse_start();
    check("start_busy", 32'(busy), 32'd1);
    n = 1;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    check("first_latency", 32'(n), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("stream_valid", 32'(instr_valid), 32'd1);
      check("stream_instr", 32'(instr), 32'(prog_q[i]));
      tick();
    end
    check("done_timing", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    instr_ready = 1'b0;

    // replay from DONE with random back-pressure
    pulse_start();
    run_check("replay", 200, 1'b1);

    // fixed back-pressure window
    pulse_start();
    n = 1;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    check("bp_latency", 32'(n), 32'd3);
    for (int i = 0; i < 5; i++) begin
      check("bp_instr", 32'(instr), 32'h14);
      check("bp_valid", 32'(instr_valid), 32'd1);
      check("bp_pc", 32'(pc), 32'd2);
      tick();
    end
    run_check("bp_release", 100, 1'b0);

    // clear, then start with an empty program
    clear = 1'b1;
    tick();
    clear = 1'b0;
    prog_q.delete();
    check("clear_len", 32'(prog_len), 32'd0);
    check("clear_state", 32'(dbg_state), 32'(ST_IDLE));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("empty_start_busy", 32'(busy), 32'd0);
    check("empty_start_state", 32'(dbg_state), 32'(ST_IDLE));

    // load and start together: load wins
    load_valid = 1'b1;
    load_data  = 8'hA5;
    start      = 1'b1;
    tick();
    load_valid = 1'b0;
    start      = 1'b0;
    check("ld_st_len", 32'(prog_len), 32'd1);
    check("ld_st_state", 32'(dbg_state), 32'(ST_IDLE));
    prog_q.push_back(8'hA5);
    pulse_start();
    run_check("single", 100, 1'b1);

    // random-length random program
    for (int r = 0; r < 4; r++) begin
      do_reset();
      len = $urandom_range(1, DEPTH);
      for (int i = 0; i < len; i++) load_word(8'($urandom));
      check("rand_len", 32'(prog_len), 32'(len));
      pulse_start();
      run_check("rand_run", 400, 1'b1);
    end

    // overflow: 17 loads into 16 slots
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) load_word(8'($urandom));
    check("ovf_len", 32'(prog_len), 32'(DEPTH));
    check("ovf_full", 32'(load_full), 32'd1);
    pulse_start();
    run_check("ovf_run", 400, 1'b1);

    // reset in RUN with two words queued
    pulse_start();
    n = 1;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    tick();
    check("mid_pc", 32'(pc), 32'd2);
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_valid", 32'(instr_valid), 32'd0);
    check("mid_rst_pc", 32'(pc), 32'd0);
    check("mid_rst_len", 32'(prog_len), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    tick();
    check("mid_rst_quiet", 32'(instr_valid), 32'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
